// File: rtl/instr_issue_unit.sv
// ---------------------------------------------------------------------------
// instr_issue_unit
//
// Issue stage that feeds the control unit. Opcodes arrive from fetch over a
// valid/ready handshake and wait in a DEPTH-entry FIFO. Each cycle one
// registered opcode/valid pair goes to the control unit. After a BRANCH or
// JUMP is issued, BUBBLES cycles with valid=0 follow. A downstream stall
// holds the head of the FIFO. A flush (redirect) discards all buffered work.
//
// Optional feature macro: ISSUE_PERF_CNT_EN
//   Defined   : issue_cnt / bubble_cnt are saturating 16-bit counters that
//               only reset clears (flush does not).
//   Undefined : both outputs are tied to zero and no counter flops exist.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, >= 2)
//   BUBBLES - valid=0 cycles inserted after each BRANCH/JUMP (0..7)
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - fetch offers in_opcode
//   in_opcode   - fetched 4-bit opcode
//   in_ready    - FIFO can accept (combinational: !full && !flush)
//   stall       - downstream cannot take a new instruction this cycle
//   flush       - discard buffered work
//   opcode      - registered opcode to the control unit
//   valid       - registered valid to the control unit
//   illegal     - one-cycle pulse: an illegal opcode (C..F) was enqueued
//   fifo_count  - current FIFO occupancy
//   issue_cnt   - issued-instruction counter
//   bubble_cnt  - inserted-bubble counter
// ---------------------------------------------------------------------------
module instr_issue_unit #(
  parameter int DEPTH   = 4,
  parameter int BUBBLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [3:0]               in_opcode,
  output logic                     in_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [3:0]               opcode,
  output logic                     valid,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              issue_cnt,
  output logic [15:0]              bubble_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_ISSUE  = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_BRANCH = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'h9;

  localparam logic [2:0] BUB_INIT    = 3'(BUBBLES);
  localparam bit         HAS_BUBBLES = (BUBBLES > 0);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [0:0]    state;
  logic [2:0]    bub_left;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       in_illegal;
  logic [3:0] head;
  logic       head_is_ctrl;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign in_ready     = !full && !flush;
  assign push         = in_valid && in_ready;
  // Only the ISSUE state pops. Flush and stall take priority over a pop.
  assign pop          = (state == ST_ISSUE) && !flush && !stall && !empty;
  assign in_illegal   = (in_opcode >= 4'hC);
  assign head         = mem[rd_ptr];
  assign head_is_ctrl = (head == OP_BRANCH) || (head == OP_JUMP);
  assign fifo_count   = count;

  // NOTE: storage arrays are not reset; valid data is tracked by the pointers
  // and the count, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_illegal ? OP_NOP : in_opcode;
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH
  // is a power of two.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge no matter how the blocks are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ISSUE;
      bub_left <= '0;
      opcode   <= OP_NOP;
      valid    <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      illegal <= push && in_illegal;
      case (state)
        ST_ISSUE: begin
          if (flush) begin
            valid  <= 1'b0;
            opcode <= OP_NOP;
          end else if (stall) begin
            valid  <= 1'b0;          // opcode keeps its last value
          end else if (empty) begin
            valid  <= 1'b0;
            opcode <= OP_NOP;
          end else begin
            valid  <= 1'b1;
            opcode <= head;
            if (head_is_ctrl && HAS_BUBBLES) begin
              state    <= ST_BUBBLE;
              bub_left <= BUB_INIT;
            end
          end
        end
        ST_BUBBLE: begin
          // Bubbles keep counting through a stall. Leaving when the counter
          // is at 1 gives exactly BUBBLES zero-valid cycles.
          valid  <= 1'b0;
          opcode <= OP_NOP;
          if (flush || bub_left <= 3'd1) begin
            state    <= ST_ISSUE;
            bub_left <= '0;
          end else begin
            bub_left <= bub_left - 3'd1;
          end
        end
        default: begin
          state    <= ST_ISSUE;
          bub_left <= '0;
        end
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] issue_q;
  logic [15:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (valid && issue_q != 16'hFFFF)                  issue_q  <= issue_q + 16'd1;
      if (state == ST_BUBBLE && bubble_q != 16'hFFFF)    bubble_q <= bubble_q + 16'd1;
    end
  end

  assign issue_cnt  = issue_q;
  assign bubble_cnt = bubble_q;
`else
  assign issue_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_unit
//
// Self-checking bench for instr_issue_unit (DEPTH=4, BUBBLES=2).
// A scoreboard queue receives the expected (legalised) opcode on every
// accepted enqueue and is cleared on flush or reset. A monitor on the falling
// edge pops one entry for every valid=1 cycle and compares it with the issued
// opcode. A table of all sixteen opcodes covers encoding, the illegal pulse
// and bubble insertion. Hand-written sequences cover latency, backpressure,
// flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_instr_issue_unit;

  localparam int DEPTH   = 4;
  localparam int BUBBLES = 2;
`ifdef ISSUE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [3:0]  opcode;
  logic        valid;
  logic        illegal;
  logic [2:0]  fifo_count;
  logic [15:0] issue_cnt;
  logic [15:0] bubble_cnt;

  instr_issue_unit #(.DEPTH(DEPTH), .BUBBLES(BUBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_opcode  (in_opcode),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .opcode     (opcode),
    .valid      (valid),
    .illegal    (illegal),
    .fifo_count (fifo_count),
    .issue_cnt  (issue_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int         total  = 0;
  int         passed = 0;
  int         mon_issues = 0;
  logic [3:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] legalize(input logic [3:0] op);
    return (op >= 4'hC) ? 4'h0 : op;
  endfunction

  // Scoreboard push side: handshake at the active edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(legalize(in_opcode));
    end
  end

  always @(negedge rst_n) begin
    sb.delete();
    mon_issues = 0;
  end

  // Scoreboard pop side: every valid=1 cycle consumes exactly one entry.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      mon_issues++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL spurious_valid: got valid=1 opcode %0h, expected no issue", opcode);
      end else begin
        check("issue_order", opcode, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (fifo_count == 0 && !valid && sb.size() == 0) done = 1'b1;
      else step();
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] exp_op;
    logic       exp_ill;
    int         exp_bub;
  } vec_t;

  vec_t       tbl [16];
  logic [3:0] fops [6];
  int         idx;
  logic       r;

  initial begin
    tbl[0]  = '{4'h0, 4'h0, 1'b0, 0};
    tbl[1]  = '{4'h1, 4'h1, 1'b0, 0};
    tbl[2]  = '{4'h2, 4'h2, 1'b0, 0};
    tbl[3]  = '{4'h3, 4'h3, 1'b0, 0};
    tbl[4]  = '{4'h4, 4'h4, 1'b0, 0};
    tbl[5]  = '{4'h5, 4'h5, 1'b0, 0};
    tbl[6]  = '{4'h6, 4'h6, 1'b0, 0};
    tbl[7]  = '{4'h7, 4'h7, 1'b0, 0};
    tbl[8]  = '{4'h8, 4'h8, 1'b0, BUBBLES};
    tbl[9]  = '{4'h9, 4'h9, 1'b0, BUBBLES};
    tbl[10] = '{4'hA, 4'hA, 1'b0, 0};
    tbl[11] = '{4'hB, 4'hB, 1'b0, 0};
    tbl[12] = '{4'hC, 4'h0, 1'b1, 0};
    tbl[13] = '{4'hD, 4'h0, 1'b1, 0};
    tbl[14] = '{4'hE, 4'h0, 1'b1, 0};
    tbl[15] = '{4'hF, 4'h0, 1'b1, 0};
    fops[0] = 4'h1; fops[1] = 4'h2; fops[2] = 4'h3;
    fops[3] = 4'h4; fops[4] = 4'h5; fops[5] = 4'h7;

    // ---------------- reset state ----------------
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; stall = 1'b0; flush = 1'b0;
    #12;
    check("rst_valid",   valid, 0);
    check("rst_opcode",  opcode, 0);
    check("rst_illegal", illegal, 0);
    check("rst_count",   fifo_count, 0);
    check("rst_ready",   in_ready, 1);
    check("rst_issue",   issue_cnt, 0);
    check("rst_bubble",  bubble_cnt, 0);
    rst_n = 1'b1;
    step();

    // ---------------- basic issue ----------------
    in_valid = 1'b1; in_opcode = 4'h1;
    step();
    check("basic_lat_valid", valid, 0);
    check("basic_count1", fifo_count, 1);
    in_opcode = 4'h2;
    step();
    check("basic_first_valid", valid, 1);
    check("basic_first_op", opcode, 4'h1);
    in_opcode = 4'h6;
    step();
    in_valid = 1'b0;
    check("basic_second_op", opcode, 4'h2);
    check("basic_second_valid", valid, 1);
    step();
    check("basic_third_op", opcode, 4'h6);
    check("basic_count0", fifo_count, 0);
    step();
    check("basic_idle_valid", valid, 0);

    // ---------------- branch bubbles ----------------
    in_valid = 1'b1; in_opcode = 4'h8;
    step();
    in_opcode = 4'h1;
    step();
    in_valid = 1'b0;
    check("br_issue_op", opcode, 4'h8);
    check("br_issue_valid", valid, 1);
    for (int b = 0; b < BUBBLES; b++) begin
      step();
      check($sformatf("br_bubble%0d_valid", b), valid, 0);
      check($sformatf("br_bubble%0d_op", b), opcode, 0);
    end
    step();
    check("br_after_valid", valid, 1);
    check("br_after_op", opcode, 4'h1);
    step();
    check("br_bubble_cnt", bubble_cnt, PERF ? BUBBLES : 0);

    // ---------------- opcode table ----------------
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_opcode = tbl[i].op;
      step();
      in_valid = 1'b0;
      check($sformatf("tbl%0d_illegal", i), illegal, tbl[i].exp_ill);
      step();
      check($sformatf("tbl%0d_valid", i), valid, 1);
      check($sformatf("tbl%0d_op", i), opcode, tbl[i].exp_op);
      check($sformatf("tbl%0d_ill_pulse", i), illegal, 0);
      for (int b = 0; b < tbl[i].exp_bub; b++) begin
        step();
        check($sformatf("tbl%0d_bub%0d", i, b), {valid, opcode}, 5'h00);
      end
      step();
      check($sformatf("tbl%0d_idle", i), valid, 0);
    end
    check("tbl_bubble_cnt", bubble_cnt, PERF ? 3 * BUBBLES : 0);
    check("tbl_issue_cnt", issue_cnt, PERF ? mon_issues : 0);

    // ---------------- full and backpressure ----------------
    stall = 1'b1; in_valid = 1'b1; idx = 0;
    for (int k = 0; k < DEPTH; k++) begin
      in_opcode = fops[idx];
      step();
      idx++;
    end
    check("full_count", fifo_count, 4);
    check("full_ready", in_ready, 0);
    check("full_stall_valid", valid, 0);
    in_opcode = fops[idx];
    step();
    check("full_hold_count", fifo_count, 4);
    stall = 1'b0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      in_opcode = fops[idx];
      r = in_ready;
      step();
      if (r) idx++;
      if (c == 0) begin
        check("full_ready_reassert", in_ready, 1);
        check("full_release_count", fifo_count, 3);
      end
    end
    in_valid = 1'b0;
    check("full_all_accepted", idx, 6);
    wait_drain("full_drain");

    // ---------------- flush in BUBBLE with count=3 ----------------
    stall = 1'b1; in_valid = 1'b1;
    in_opcode = 4'h9; step();
    in_opcode = 4'h1; step();
    in_opcode = 4'h2; step();
    check("fl_pre_count", fifo_count, 3);
    stall = 1'b0; in_opcode = 4'h4;
    step();
    check("fl_jump_op", opcode, 4'h9);
    check("fl_jump_count", fifo_count, 3);
    flush = 1'b1; in_opcode = 4'h5;
    #1;
    check("fl_ready_low", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count0", fifo_count, 0);
    check("fl_valid0", valid, 0);
    check("fl_opcode0", opcode, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("fl_quiet%0d", c), {valid, fifo_count}, 4'h0);
    end
    in_valid = 1'b1; in_opcode = 4'h3;
    step();
    in_valid = 1'b0;
    step();
    check("fl_resume_op", opcode, 4'h3);
    check("fl_resume_valid", valid, 1);
    wait_drain("fl_drain");

    // ---------------- asynchronous reset mid-issue ----------------
    stall = 1'b1; in_valid = 1'b1;
    in_opcode = 4'h1; step();
    in_opcode = 4'h2; step();
    in_opcode = 4'h3; step();
    stall = 1'b0; in_valid = 1'b0;
    step();
    check("ar_pre_valid", valid, 1);
    check("ar_pre_count", fifo_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", valid, 0);
    check("ar_opcode", opcode, 0);
    check("ar_count", fifo_count, 0);
    check("ar_ready", in_ready, 1);
    check("ar_issue_cnt", issue_cnt, 0);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b1; in_opcode = 4'h5;
    step();
    in_valid = 1'b0;
    check("ar_post_lat", valid, 0);
    check("ar_post_count", fifo_count, 1);
    step();
    check("ar_post_valid", valid, 1);
    check("ar_post_op", opcode, 4'h5);
    step();
    check("ar_post_issue_cnt", issue_cnt, PERF ? mon_issues : 0);
    wait_drain("ar_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
